// File: rtl/exe_stage_pkg.sv
// rtl/exe_stage_pkg.sv - shared ALU op codes, mul/div state type and width defaults
package exe_stage_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int MD_CYCLES_DEF = 32;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_AND   = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd3;
    localparam logic [4:0] ALU_XOR   = 5'd4;
    localparam logic [4:0] ALU_NOR   = 5'd5;
    localparam logic [4:0] ALU_SLT   = 5'd6;
    localparam logic [4:0] ALU_SLTU  = 5'd7;
    localparam logic [4:0] ALU_SLL   = 5'd8;
    localparam logic [4:0] ALU_SRL   = 5'd9;
    localparam logic [4:0] ALU_SRA   = 5'd10;
    localparam logic [4:0] ALU_LUI   = 5'd11;
    localparam logic [4:0] ALU_MULT  = 5'd12;
    localparam logic [4:0] ALU_MULTU = 5'd13;
    localparam logic [4:0] ALU_DIV   = 5'd14;
    localparam logic [4:0] ALU_DIVU  = 5'd15;
    localparam logic [4:0] ALU_MFHI  = 5'd16;
    localparam logic [4:0] ALU_MFLO  = 5'd17;
    localparam logic [4:0] ALU_MTHI  = 5'd18;
    localparam logic [4:0] ALU_MTLO  = 5'd19;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/exe_stage_muldiv_unit.sv
// rtl/exe_stage_muldiv_unit.sv - iterative shift-add multiply / restoring divide with HI/LO
module muldiv_unit
    import exe_stage_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MD_CYCLES = MD_CYCLES_DEF,
    localparam int CNT_W    = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [1:0]        op_i,      // [1]: divide, [0]: unsigned
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              mthi_i,
    input  logic              mtlo_i,
    output logic              busy_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    md_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W:0]       acc_q, acc_d;     // partial product high half / remainder
    logic [DATA_W-1:0]     q_q, q_d;         // multiplier / quotient shift register
    logic [DATA_W-1:0]     m_q, m_d;         // multiplicand / divisor magnitude
    logic                  is_div_q, is_div_d;
    logic                  neg_q_q, neg_q_d; // product or quotient negative
    logic                  neg_r_q, neg_r_d; // remainder negative
    logic                  bzero_q, bzero_d;
    logic [DATA_W-1:0]     hi_q, hi_d, lo_q, lo_d;

    logic [DATA_W:0]       mul_sum;
    logic [DATA_W:0]       div_rem_sh;
    logic [DATA_W+1:0]     div_diff;
    logic [DATA_W:0]       acc_step;
    logic [DATA_W-1:0]     q_step;
    logic [2*DATA_W-1:0]   prod;
    logic [DATA_W-1:0]     quot, rem;
    logic                  a_neg, b_neg;

    always_comb begin
        mul_sum    = {1'b0, acc_q[DATA_W-1:0]} + (q_q[0] ? {1'b0, m_q} : '0);
        div_rem_sh = {acc_q[DATA_W-1:0], q_q[DATA_W-1]};
        div_diff   = {1'b0, div_rem_sh} - {2'b00, m_q};
        if (is_div_q) begin
            if (!div_diff[DATA_W+1]) begin
                acc_step = div_diff[DATA_W:0];
                q_step   = {q_q[DATA_W-2:0], 1'b1};
            end else begin
                acc_step = div_rem_sh;
                q_step   = {q_q[DATA_W-2:0], 1'b0};
            end
        end else begin
            acc_step = {1'b0, mul_sum[DATA_W:1]};
            q_step   = {mul_sum[0], q_q[DATA_W-1:1]};
        end
        prod = {acc_step[DATA_W-1:0], q_step};
        if (neg_q_q) prod = -prod;
        quot = neg_q_q ? -q_step : q_step;
        if (bzero_q) quot = '1;
        rem  = neg_r_q ? -acc_step[DATA_W-1:0] : acc_step[DATA_W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        q_d      = q_q;
        m_d      = m_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        bzero_d  = bzero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_o   = 1'b0;
        a_neg    = ~op_i[0] & a_i[DATA_W-1];
        b_neg    = ~op_i[0] & b_i[DATA_W-1];
        case (state_q)
            MD_IDLE: begin
                if (start_i) begin
                    busy_o   = 1'b1;
                    state_d  = MD_BUSY;
                    cnt_d    = '0;
                    acc_d    = '0;
                    q_d      = a_neg ? -a_i : a_i;
                    m_d      = b_neg ? -b_i : b_i;
                    is_div_d = op_i[1];
                    neg_q_d  = a_neg ^ b_neg;
                    neg_r_d  = a_neg;
                    bzero_d  = (b_i == '0);
                end else begin
                    if (mthi_i) hi_d = a_i;
                    if (mtlo_i) lo_d = a_i;
                end
            end
            MD_BUSY: begin
                busy_o = 1'b1;
                acc_d  = acc_step;
                q_d    = q_step;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MD_CYCLES - 1)) begin
                    state_d = MD_DONE;
                    if (is_div_q) begin
                        hi_d = rem;
                        lo_d = quot;
                    end else begin
                        hi_d = prod[2*DATA_W-1:DATA_W];
                        lo_d = prod[DATA_W-1:0];
                    end
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            m_q      <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            bzero_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            m_q      <= m_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            bzero_q  <= bzero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage ALU, branch target, HI/LO access and EX/MEM register
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MD_CYCLES = MD_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc_4_in,
    input  logic [DATA_W-1:0] register_read1_in,
    input  logic [DATA_W-1:0] register_read2_in,
    input  logic [DATA_W-1:0] ext_in,
    input  logic [4:0]        ir_2016_in,
    input  logic [4:0]        ir_1511_in,
    input  logic              Reg_Dst_in,
    input  logic              ALUSrc_in,
    input  logic [4:0]        ALUctrl_in,
    input  logic              Reg_Write_in,
    input  logic              Mem2R_in,
    input  logic              Mem_Write_in,
    input  logic              Mem_Read_in,
    input  logic              Branch_in,
    input  logic              bne_in,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] write_data_out,
    output logic [4:0]        write_reg_out,
    output logic [DATA_W-1:0] branch_target_out,
    output logic              zero_out,
    output logic              Reg_Write_out,
    output logic              Mem2R_out,
    output logic              Mem_Write_out,
    output logic              Mem_Read_out,
    output logic              Branch_out,
    output logic              bne_out,
    output logic              stall_out
);

    logic [DATA_W-1:0] op_a, op_b, a_minus_b, alu_res, hi, lo;
    logic [4:0]        shamt;
    logic              is_md, md_busy;

    assign op_a      = register_read1_in;
    assign op_b      = ALUSrc_in ? ext_in : register_read2_in;
    assign shamt     = ext_in[10:6];
    assign a_minus_b = op_a - op_b;
    assign is_md     = (ALUctrl_in[4:2] == 3'b011);
    // Reset must release upstream stages at once, even with a mul/div still in ID/EX.
    assign stall_out = md_busy & ~rst;

    muldiv_unit #(
        .DATA_W    (DATA_W),
        .MD_CYCLES (MD_CYCLES)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start_i (is_md),
        .op_i    (ALUctrl_in[1:0]),
        .a_i     (op_a),
        .b_i     (op_b),
        .mthi_i  (ALUctrl_in == ALU_MTHI),
        .mtlo_i  (ALUctrl_in == ALU_MTLO),
        .busy_o  (md_busy),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    always_comb begin
        case (ALUctrl_in)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = a_minus_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_NOR:  alu_res = ~(op_a | op_b);
            ALU_SLT:  alu_res = DATA_W'($signed(op_a) < $signed(op_b));
            ALU_SLTU: alu_res = DATA_W'(op_a < op_b);
            ALU_SLL:  alu_res = op_b << shamt;
            ALU_SRL:  alu_res = op_b >> shamt;
            ALU_SRA:  alu_res = $signed(op_b) >>> shamt;
            ALU_LUI:  alu_res = op_b << 16;
            ALU_MFHI: alu_res = hi;
            ALU_MFLO: alu_res = lo;
            default:  alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || md_busy) begin
            alu_result_out    <= '0;
            write_data_out    <= '0;
            write_reg_out     <= '0;
            branch_target_out <= '0;
            zero_out          <= 1'b0;
            Reg_Write_out     <= 1'b0;
            Mem2R_out         <= 1'b0;
            Mem_Write_out     <= 1'b0;
            Mem_Read_out      <= 1'b0;
            Branch_out        <= 1'b0;
            bne_out           <= 1'b0;
        end else begin
            alu_result_out    <= alu_res;
            write_data_out    <= register_read2_in;
            write_reg_out     <= Reg_Dst_in ? ir_1511_in : ir_2016_in;
            branch_target_out <= pc_4_in + (ext_in << 2);
            zero_out          <= (a_minus_b == '0);
            Reg_Write_out     <= Reg_Write_in & ~is_md;
            Mem2R_out         <= Mem2R_in;
            Mem_Write_out     <= Mem_Write_in;
            Mem_Read_out      <= Mem_Read_in;
            Branch_out        <= Branch_in;
            bne_out           <= bne_in;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - directed self-checking bench for exe_stage
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_4_in, register_read1_in, register_read2_in, ext_in;
    logic [4:0]  ir_2016_in, ir_1511_in, ALUctrl_in;
    logic        Reg_Dst_in, ALUSrc_in, Reg_Write_in, Mem2R_in, Mem_Write_in, Mem_Read_in, Branch_in, bne_in;
    logic [31:0] alu_result_out, write_data_out, branch_target_out;
    logic [4:0]  write_reg_out;
    logic        zero_out, Reg_Write_out, Mem2R_out, Mem_Write_out, Mem_Read_out, Branch_out, bne_out, stall_out;

    int checks = 0;
    int errors = 0;
    int cyc;
    bit bub_ok;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk               (clk),
        .rst               (rst),
        .pc_4_in           (pc_4_in),
        .register_read1_in (register_read1_in),
        .register_read2_in (register_read2_in),
        .ext_in            (ext_in),
        .ir_2016_in        (ir_2016_in),
        .ir_1511_in        (ir_1511_in),
        .Reg_Dst_in        (Reg_Dst_in),
        .ALUSrc_in         (ALUSrc_in),
        .ALUctrl_in        (ALUctrl_in),
        .Reg_Write_in      (Reg_Write_in),
        .Mem2R_in          (Mem2R_in),
        .Mem_Write_in      (Mem_Write_in),
        .Mem_Read_in       (Mem_Read_in),
        .Branch_in         (Branch_in),
        .bne_in            (bne_in),
        .alu_result_out    (alu_result_out),
        .write_data_out    (write_data_out),
        .write_reg_out     (write_reg_out),
        .branch_target_out (branch_target_out),
        .zero_out          (zero_out),
        .Reg_Write_out     (Reg_Write_out),
        .Mem2R_out         (Mem2R_out),
        .Mem_Write_out     (Mem_Write_out),
        .Mem_Read_out      (Mem_Read_out),
        .Branch_out        (Branch_out),
        .bne_out           (bne_out),
        .stall_out         (stall_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        pc_4_in = '0; register_read1_in = '0; register_read2_in = '0; ext_in = '0;
        ir_2016_in = '0; ir_1511_in = '0; ALUctrl_in = 5'd0;
        Reg_Dst_in = 0; ALUSrc_in = 0; Reg_Write_in = 0; Mem2R_in = 0;
        Mem_Write_in = 0; Mem_Read_in = 0; Branch_in = 0; bne_in = 0;
    endtask

    task automatic set_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        clear_in();
        ALUctrl_in = op; register_read1_in = a; register_read2_in = b; Reg_Write_in = 1;
    endtask

    // Counts stalled cycles until stall drops (bounded) and checks every captured slot is a bubble.
    task automatic md_run(output int n, output bit ok);
        n = 0;
        ok = 1;
        while (stall_out && n < 100) begin
            tick();
            n++;
            if (Reg_Write_out !== 1'b0 || Mem_Write_out !== 1'b0 || alu_result_out !== 32'd0) ok = 0;
        end
    endtask

    initial begin
        clear_in();
        rst = 1;
        register_read1_in = 32'h1111; Reg_Write_in = 1; Branch_in = 1; pc_4_in = 32'h40;
        tick();
        tick();
        chk("reset_alu", alu_result_out, 32'd0);
        chk("reset_rw", Reg_Write_out, 32'd0);
        chk("reset_target", branch_target_out, 32'd0);
        chk("reset_stall", stall_out, 32'd0);
        rst = 0;

        // ADD with immediate, rd destination
        clear_in();
        ALUctrl_in = 5'd0; register_read1_in = 32'd5; ext_in = 32'hFFFF_FFFD; ALUSrc_in = 1;
        Reg_Dst_in = 1; ir_1511_in = 5'd7; ir_2016_in = 5'd3; Reg_Write_in = 1; register_read2_in = 32'h55;
        tick();
        chk("add_result", alu_result_out, 32'd2);
        chk("add_wreg", write_reg_out, 32'd7);
        chk("add_rw", Reg_Write_out, 32'd1);
        chk("add_wdata", write_data_out, 32'h55);
        chk("add_zero", zero_out, 32'd0);

        // SUB equal operands with branch
        clear_in();
        ALUctrl_in = 5'd1; register_read1_in = 32'h1234; register_read2_in = 32'h1234;
        Branch_in = 1; pc_4_in = 32'h100; ext_in = 32'd4; ir_2016_in = 5'd9;
        tick();
        chk("sub_zero", zero_out, 32'd1);
        chk("sub_target", branch_target_out, 32'h110);
        chk("sub_branch", Branch_out, 32'd1);
        chk("sub_result", alu_result_out, 32'd0);
        chk("sub_wreg_rt", write_reg_out, 32'd9);

        set_op(5'd6, 32'hFFFF_FFFF, 32'd1);
        tick();
        chk("slt", alu_result_out, 32'd1);
        set_op(5'd7, 32'hFFFF_FFFF, 32'd1);
        tick();
        chk("sltu", alu_result_out, 32'd0);
        set_op(5'd10, 32'd0, 32'h8000_0000);
        ext_in = 32'h100;
        tick();
        chk("sra", alu_result_out, 32'hF800_0000);
        set_op(5'd11, 32'd0, 32'd0);
        ALUSrc_in = 1; ext_in = 32'h1234;
        tick();
        chk("lui", alu_result_out, 32'h1234_0000);
        set_op(5'd5, 32'd0, 32'd0);
        tick();
        chk("nor", alu_result_out, 32'hFFFF_FFFF);
        set_op(5'd20, 32'd3, 32'd4);
        tick();
        chk("op20", alu_result_out, 32'd0);

        // MULT -3 * 5
        set_op(5'd12, 32'hFFFF_FFFD, 32'd5);
        #1;
        chk("mult_stall_start", stall_out, 32'd1);
        md_run(cyc, bub_ok);
        chk("mult_stall_cycles", cyc, 32'd33);
        chk("mult_bubbles", bub_ok, 32'd1);
        tick();
        chk("mult_retire_rw", Reg_Write_out, 32'd0);
        set_op(5'd16, 32'd0, 32'd0);
        tick();
        chk("mult_hi", alu_result_out, 32'hFFFF_FFFF);
        set_op(5'd17, 32'd0, 32'd0);
        tick();
        chk("mult_lo", alu_result_out, 32'hFFFF_FFF1);

        // DIV 7 / -2
        set_op(5'd14, 32'd7, 32'hFFFF_FFFE);
        #1;
        md_run(cyc, bub_ok);
        chk("div_cycles", cyc, 32'd33);
        tick();
        set_op(5'd17, 32'd0, 32'd0);
        tick();
        chk("div_lo", alu_result_out, 32'hFFFF_FFFD);
        set_op(5'd16, 32'd0, 32'd0);
        tick();
        chk("div_hi", alu_result_out, 32'd1);

        // DIVU by zero
        set_op(5'd15, 32'd9, 32'd0);
        #1;
        md_run(cyc, bub_ok);
        chk("divu0_cycles", cyc, 32'd33);
        tick();
        set_op(5'd17, 32'd0, 32'd0);
        tick();
        chk("divu0_lo", alu_result_out, 32'hFFFF_FFFF);
        set_op(5'd16, 32'd0, 32'd0);
        tick();
        chk("divu0_hi", alu_result_out, 32'd9);

        // Reset during BUSY cycle 10
        set_op(5'd12, 32'd3, 32'd3);
        repeat (11) tick();
        chk("busy_before_rst", stall_out, 32'd1);
        rst = 1;
        #1;
        chk("rst_stall_drop", stall_out, 32'd0);
        chk("rst_alu", alu_result_out, 32'd0);
        set_op(5'd16, 32'd0, 32'd0);
        tick();
        rst = 0;
        tick();
        chk("rst_hi", alu_result_out, 32'd0);
        set_op(5'd17, 32'd0, 32'd0);
        tick();
        chk("rst_lo", alu_result_out, 32'd0);

        // MULTU after reset runs full length
        set_op(5'd13, 32'h0001_0000, 32'h0001_0000);
        #1;
        md_run(cyc, bub_ok);
        chk("multu_cycles", cyc, 32'd33);
        tick();
        set_op(5'd16, 32'd0, 32'd0);
        tick();
        chk("multu_hi", alu_result_out, 32'd1);
        set_op(5'd17, 32'd0, 32'd0);
        tick();
        chk("multu_lo", alu_result_out, 32'd0);

        // MTHI then MFHI back-to-back
        set_op(5'd18, 32'hCAFE, 32'd0);
        #1;
        chk("mthi_nostall", stall_out, 32'd0);
        tick();
        set_op(5'd16, 32'd0, 32'd0);
        #1;
        chk("mfhi_nostall", stall_out, 32'd0);
        tick();
        chk("mthi_mfhi", alu_result_out, 32'hCAFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
